// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} arb_owner_t;

  // Fetches always read a whole word.
  localparam logic [3:0] BE_FULL = 4'hF;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_DM = 1;

  // Counter preload: BUSY lasts MEM_LATENCY cycles, counting down to zero.
  function automatic logic [3:0] lat_load(input int lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational winner select: DM first, unless IF has been starved too long.
module mem_arb_priority (
  input  logic       i_if_req,
  input  logic       i_dm_req,
  input  logic       i_starve_full,
  output logic [1:0] o_grant
);
  import mem_arb_pkg::*;

  // One-hot grant; the starvation override flips priority only when IF waits.
  always_comb begin
    o_grant = 2'b00;
    if (i_dm_req && !(i_if_req && i_starve_full)) begin
      o_grant[GNT_DM] = 1'b1;
    end else if (i_if_req) begin
      o_grant[GNT_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and DM accesses onto one fixed-latency single-ported memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [WIDTH-1:0]      if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WIDTH-1:0]      if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [WIDTH-1:0]      dm_addr,
  input  logic [WIDTH-1:0]      dm_wdata,
  input  logic [3:0]            dm_be,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [WIDTH-1:0]      dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  stall_if,
  output logic                  stall_mem
);

  localparam logic [3:0] LAT_LOAD   = lat_load(MEM_LATENCY);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  arb_state_t       r_state;
  arb_owner_t       r_owner;
  logic             r_store;
  logic [3:0]       r_cnt;
  logic [3:0]       r_starve;
  logic [WIDTH-1:0] r_if_rdata;
  logic [WIDTH-1:0] r_dm_rdata;
  logic             r_if_rvalid;
  logic             r_dm_rvalid;

  logic       w_idle;
  logic       w_starve_full;
  logic [1:0] w_grant;
  logic       w_if_gnt;
  logic       w_dm_gnt;
  logic       w_unused;

  assign w_idle        = (r_state == ARB_IDLE);
  assign w_starve_full = (r_starve == STARVE_TOP);

  // Addresses are silently truncated to the memory width.
  assign w_unused = ^{if_addr[WIDTH-1:ADDR_WIDTH], dm_addr[WIDTH-1:ADDR_WIDTH]};

  mem_arb_priority u_priority (
    .i_if_req      (if_req),
    .i_dm_req      (dm_req),
    .i_starve_full (w_starve_full),
    .o_grant       (w_grant)
  );

  // Grants only happen in IDLE; rst gates everything so outputs read 0 in reset.
  assign w_if_gnt = rst & w_idle & w_grant[GNT_IF];
  assign w_dm_gnt = rst & w_idle & w_grant[GNT_DM];

  assign if_gnt    = w_if_gnt;
  assign dm_gnt    = w_dm_gnt;
  assign if_rvalid = r_if_rvalid;
  assign dm_rvalid = r_dm_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign stall_if  = rst & if_req & ~r_if_rvalid;
  assign stall_mem = rst & dm_req & ~r_dm_rvalid;

  // Memory strobe and payload come straight from the winner in the grant cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'h0;
    if (w_dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr[ADDR_WIDTH-1:0];
      mem_wdata = dm_wdata;
      mem_be    = dm_be;
    end else if (w_if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_WIDTH-1:0];
      mem_be   = BE_FULL;
    end
  end

  // Transaction FSM: latch owner on grant, count latency, capture data, pulse rvalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_IF;
      r_store     <= 1'b0;
      r_cnt       <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_dm_gnt) begin
            r_owner <= OWN_DM;
            r_store <= dm_we;
            r_cnt   <= LAT_LOAD;
            r_state <= ARB_BUSY;
          end else if (w_if_gnt) begin
            r_owner <= OWN_IF;
            r_store <= 1'b0;
            r_cnt   <= LAT_LOAD;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (r_cnt == 4'd0) begin
            // Last latency cycle: read data is valid now, rvalid follows next cycle.
            r_state <= ARB_IDLE;
            if (r_owner == OWN_DM) begin
              r_dm_rvalid <= 1'b1;
              if (!r_store) begin
                r_dm_rdata <= mem_rdata;
              end
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Count DM wins while IF waits; an IF grant or an idle IF clears the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (w_idle) begin
      if (w_if_gnt) begin
        r_starve <= '0;
      end else if (w_dm_gnt && if_req) begin
        if (!w_starve_full) begin
          r_starve <= r_starve + 4'd1;
        end
      end else if (!if_req) begin
        r_starve <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a memory model and rdata scoreboards.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = 4'h0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_model [4096];
  logic [31:0] ref_mem   [4096];
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [11:0] p1_a = '0, p2_a = '0;
  logic [31:0] if_q [$];
  logic [31:0] dm_q [$];
  logic [31:0] last_dm = '0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // Memory with a two-cycle read pipeline; garbage is driven when no read is due.
  always @(posedge clk) begin
    p1_v <= mem_en & ~mem_we;
    p1_a <= mem_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end
  assign mem_rdata = p2_v ? mem_model[p2_a] : 32'hA5A5_5A5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // {if_gnt, dm_gnt, mem_en, if_rvalid, dm_rvalid, stall_if, stall_mem}
  function automatic logic [31:0] vec();
    return {25'b0, if_gnt, dm_gnt, mem_en, if_rvalid, dm_rvalid, stall_if, stall_mem};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [6:0] exp);
    @(negedge clk);
    chk(tag, vec(), {25'b0, exp});
  endtask

  function automatic logic [31:0] pattern(input int a);
    return 32'h1000_0000 + (a * 32'h0001_0203);
  endfunction

  task automatic push_if(input logic [31:0] a);
    if_q.push_back(ref_mem[a[11:0]]);
  endtask

  task automatic push_dm_load(input logic [31:0] a);
    last_dm = ref_mem[a[11:0]];
    dm_q.push_back(last_dm);
  endtask

  task automatic push_dm_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) ref_mem[a[11:0]][8*b +: 8] = d[8*b +: 8];
    end
    dm_q.push_back(last_dm);
  endtask

  // Scoreboard: every rvalid pops one expected word for that requester.
  always @(negedge clk) begin
    if (if_rvalid) begin
      chk("if_rvalid_expected", 32'(if_q.size() != 0), 32'd1);
      if (if_q.size() != 0) chk("if_rdata", if_rdata, if_q.pop_front());
    end
    if (dm_rvalid) begin
      chk("dm_rvalid_expected", 32'(dm_q.size() != 0), 32'd1);
      if (dm_q.size() != 0) chk("dm_rdata", dm_rdata, dm_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_model[i] = pattern(i);
      ref_mem[i]   = pattern(i);
    end
    mem_model[12'h010] = 32'hDEADBEEF;
    ref_mem[12'h010]   = 32'hDEADBEEF;

    // Reset: requests present, but every output must stay 0.
    if_req = 1'b1;
    dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_flags", vec(), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_mem", {19'b0, mem_we, mem_addr}, 32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // 1: single fetch, then a chained fetch issued in the rvalid cycle.
    nxt(); if_req = 1'b1; if_addr = 32'h10; push_if(32'h10);
    step("t1_c0", 7'b1010010);
    chk("t1_mem_addr", {20'b0, mem_addr}, 32'h010);
    chk("t1_mem_be_we", {27'b0, mem_we, mem_be}, 32'h0F);
    nxt(); step("t1_c1", 7'b0000010);
    nxt(); step("t1_c2", 7'b0000010);
    nxt(); if_addr = 32'h14; push_if(32'h14);
    step("t1_c3", 7'b1011000);
    nxt(); step("t1_c4", 7'b0000010);
    nxt(); step("t1_c5", 7'b0000010);
    nxt(); if_req = 1'b0;
    step("t1_c6", 7'b0001000);

    // 2: simultaneous requests, DM wins first.
    nxt(); if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    push_if(32'h20); push_dm_load(32'h40);
    step("t2_c0", 7'b0110011);
    chk("t2_mem_addr", {20'b0, mem_addr}, 32'h040);
    nxt(); step("t2_c1", 7'b0000011);
    nxt(); step("t2_c2", 7'b0000011);
    nxt(); dm_req = 1'b0;
    step("t2_c3", 7'b1010110);
    nxt(); step("t2_c4", 7'b0000010);
    nxt(); step("t2_c5", 7'b0000010);
    nxt(); if_req = 1'b0;
    step("t2_c6", 7'b0001000);

    // 3 + 6: partial store, then back-to-back loads each issued in the prior rvalid cycle.
    nxt(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'h12345678; dm_be = 4'b0011;
    push_dm_store(32'h44, 32'h12345678, 4'b0011);
    step("t3_c0", 7'b0110001);
    chk("t3_mem_be_we", {27'b0, mem_we, mem_be}, 32'h13);
    chk("t3_mem_wdata", mem_wdata, 32'h12345678);
    chk("t3_mem_addr", {20'b0, mem_addr}, 32'h044);
    nxt(); step("t3_c1", 7'b0000001);
    nxt(); step("t3_c2", 7'b0000001);
    nxt(); dm_we = 1'b0; dm_be = 4'h0; push_dm_load(32'h44);
    step("t6_c3", 7'b0110100);
    nxt(); step("t6_c4", 7'b0000001);
    nxt(); step("t6_c5", 7'b0000001);
    nxt(); dm_addr = 32'h48; push_dm_load(32'h48);
    step("t6_c6", 7'b0110100);
    nxt(); step("t6_c7", 7'b0000001);
    nxt(); step("t6_c8", 7'b0000001);
    nxt(); dm_req = 1'b0;
    step("t6_c9", 7'b0000100);

    // 4: both held; four DM wins, forced IF, then DM again.
    for (int s = 0; s < 6; s++) begin
      logic g_if, rv_if, rv_dm;
      g_if  = (s == 4);
      rv_if = (s == 5);
      rv_dm = (s != 0) && (s != 5);
      nxt();
      if (s == 0) begin
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h90;
      end
      if (g_if) push_if(32'h80);
      else push_dm_load(32'h90);
      step($sformatf("t4_slot%0d", s), {g_if, ~g_if, 1'b1, rv_if, rv_dm, ~rv_if, ~rv_dm});
      nxt(); step($sformatf("t4_slot%0d_b1", s), 7'b0000011);
      nxt(); step($sformatf("t4_slot%0d_b2", s), 7'b0000011);
    end
    nxt(); if_req = 1'b0; dm_req = 1'b0;
    step("t4_end", 7'b0000100);

    // 5: reset mid-transaction drops the DM load; IF is granted on release.
    nxt(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    step("t5_c0", 7'b0110001);
    nxt(); rst = 1'b0;
    #1;
    chk("t5_async_rst", vec(), 32'd0);
    chk("t5_mem_addr", {20'b0, mem_addr}, 32'd0);
    dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h200;
    step("t5_rst_c1", 7'b0000000);
    nxt(); step("t5_rst_c2", 7'b0000000);
    nxt(); step("t5_rst_c3", 7'b0000000);
    chk("t5_dm_rdata", dm_rdata, 32'd0);
    push_if(32'h200);
    rst = 1'b1;
    #1;
    chk("t5_release_gnt", vec(), 32'b1010010);
    nxt(); step("t5_c4", 7'b0000010);
    nxt(); step("t5_c5", 7'b0000010);
    nxt(); if_req = 1'b0;
    step("t5_c6", 7'b0001000);
    nxt(); step("t5_idle", 7'b0000000);

    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
